// File: rtl/arbiter_ctrl.sv
// arbiter_ctrl: control FSM for the shared pmem port. Grants the pmem port to
// either the icache or the dcache. Contention between them is resolved
// round-robin. Every transaction is followed by a one-cycle turnaround.
// A watchdog catches transactions whose pmem_resp never arrives.
module arbiter_ctrl #(
    parameter int TIMEOUT_CYCLES = 1023,  // 0 disables the watchdog
    parameter int CNT_W          = 10     // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic iread,
    input  logic dread,
    input  logic dwrite,
    input  logic pmem_resp,
    output logic iread_gnt,
    output logic dread_gnt,
    output logic dwrite_gnt,
    output logic cache_sel,
    output logic busy,
    output logic timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        TURN    = 2'd3
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam bit               WDOG_EN     = (TIMEOUT_CYCLES != 0);

    state_t           state, state_next;
    side_t            last_served, last_served_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             err_q, err_next;

    logic i_pend;
    logic d_pend;
    logic trip;

    assign i_pend      = iread;
    assign d_pend      = dread | dwrite;
    assign timeout_err = err_q;

    // The watchdog fires on the last permitted wait cycle.
    // A pmem_resp in that same cycle counts as a normal completion.
    assign trip = WDOG_EN && (wait_cnt == TIMEOUT_VAL) && !pmem_resp;

    // State, round-robin pointer, wait counter and sticky error registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of its peers.
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= SIDE_D;
            wait_cnt    <= '0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_next;
            last_served <= last_served_next;
            wait_cnt    <= wait_cnt_next;
            err_q       <= err_next;
        end
    end

    // Next-state, counter and error update, plus combinational output decode
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can
        // leave a variable unassigned and infer a latch.
        state_next       = state;
        last_served_next = last_served;
        wait_cnt_next    = wait_cnt;
        err_next         = err_q;
        iread_gnt        = 1'b0;
        dread_gnt        = 1'b0;
        dwrite_gnt       = 1'b0;
        cache_sel        = 1'b0;
        busy             = 1'b1;

        unique case (state)
            IDLE: begin
                busy          = 1'b0;
                wait_cnt_next = '0;
                if (pmem_resp) err_next = 1'b1;
                if (i_pend && d_pend)
                    state_next = (last_served == SIDE_D) ? SERVE_I : SERVE_D;
                else if (i_pend)
                    state_next = SERVE_I;
                else if (d_pend)
                    state_next = SERVE_D;
            end

            SERVE_I: begin
                iread_gnt = iread;
                // The owner withdrew its request before completion.
                if (!i_pend && !pmem_resp) err_next = 1'b1;
                if (pmem_resp || trip) begin
                    state_next       = TURN;
                    last_served_next = SIDE_I;
                    if (trip) err_next = 1'b1;
                end else if (wait_cnt != CNT_MAX) begin
                    wait_cnt_next = wait_cnt + CNT_ONE;
                end
            end

            SERVE_D: begin
                cache_sel  = 1'b1;
                dread_gnt  = dread;
                dwrite_gnt = dwrite;
                if (!d_pend && !pmem_resp) err_next = 1'b1;
                if (pmem_resp || trip) begin
                    state_next       = TURN;
                    last_served_next = SIDE_D;
                    if (trip) err_next = 1'b1;
                end else if (wait_cnt != CNT_MAX) begin
                    wait_cnt_next = wait_cnt + CNT_ONE;
                end
            end

            TURN: begin
                // last_served already names the owner that just finished.
                cache_sel     = (last_served == SIDE_D);
                wait_cnt_next = '0;
                if (pmem_resp) err_next = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_arbiter_ctrl.sv
// Testbench for arbiter_ctrl. The driver runs a behavioural reference model
// and queues the expected outputs for every cycle. A separate monitor
// compares the DUT outputs against the head of that queue each cycle.
module tb_arbiter_ctrl;

    localparam int TO = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n, iread, dread, dwrite, pmem_resp;
    logic iread_gnt, dread_gnt, dwrite_gnt, cache_sel, busy, timeout_err;

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    arbiter_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iread      (iread),
        .dread      (dread),
        .dwrite     (dwrite),
        .pmem_resp  (pmem_resp),
        .iread_gnt  (iread_gnt),
        .dread_gnt  (dread_gnt),
        .dwrite_gnt (dwrite_gnt),
        .cache_sel  (cache_sel),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic ig;
        logic dg;
        logic wg;
        logic sel;
        logic busy;
        logic err;
    } out_t;

    typedef struct {
        out_t o;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: owner of the port, turnaround gap, round-robin memory
    bit m_serving;   // a transaction currently owns pmem
    bit m_side;      // owner side: 0 = icache, 1 = dcache
    bit m_gap;       // the single dead cycle after a transaction
    bit m_last;      // side that finished most recently
    bit m_err;       // sticky error
    int m_waited;    // cycles the current owner has waited without pmem_resp

    task automatic model_reset();
        m_serving = 1'b0;
        m_side    = 1'b0;
        m_gap     = 1'b0;
        m_last    = 1'b1;
        m_err     = 1'b0;
        m_waited  = 0;
    endtask

    function automatic out_t model_out(bit i, bit d, bit w);
        out_t o;
        o     = '0;
        o.err = m_err;
        if (m_serving) begin
            o.busy = 1'b1;
            o.sel  = m_side;
            if (m_side) begin
                o.dg = d;
                o.wg = w;
            end else begin
                o.ig = i;
            end
        end else if (m_gap) begin
            o.busy = 1'b1;
            o.sel  = m_last;
        end
        return o;
    endfunction

    task automatic model_step(bit i, bit d, bit w, bit r, bit rs);
        bit want_i, want_d, req, tripped;
        if (!rs) begin
            model_reset();
            return;
        end
        if (m_serving) begin
            req     = m_side ? (d | w) : i;
            tripped = !r && (TO != 0) && (m_waited == TO);
            if (!req && !r) m_err = 1'b1;
            if (r || tripped) begin
                if (tripped) m_err = 1'b1;
                m_last    = m_side;
                m_serving = 1'b0;
                m_gap     = 1'b1;
            end else begin
                m_waited++;
            end
        end else if (m_gap) begin
            if (r) m_err = 1'b1;
            m_gap = 1'b0;
        end else begin
            if (r) m_err = 1'b1;
            want_i = i;
            want_d = d | w;
            if (want_i || want_d) begin
                if (want_i && want_d) m_side = ~m_last;
                else                  m_side = want_d;
                m_serving = 1'b1;
                m_waited  = 0;
            end
        end
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, advance model
    task automatic step(input bit i, input bit d, input bit w, input bit r,
                        input bit rs = 1'b1);
        exp_t e;
        @(negedge clk);
        iread     = i;
        dread     = d;
        dwrite    = w;
        pmem_resp = r;
        rst_n     = rs;
        e.o       = model_out(i, d, w);
        e.cyc     = cyc;
        exp_q.push_back(e);
        model_step(i, d, w, r, rs);
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Hold requests steady; memory answers once the owner has waited lat cycles
    task automatic serve_run(input bit i, input bit d, input bit w,
                             input int lat, input int n);
        for (int k = 0; k < n; k++)
            step(i, d, w, m_serving && (m_waited == lat));
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation
    initial begin
        exp_t e;
        out_t got;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{iread_gnt, dread_gnt, dwrite_gnt, cache_sel, busy, timeout_err};
                checks++;
                if (got !== e.o) begin
                    failures++;
                    $display("FAIL cycle%0d outputs ig/dg/wg/sel/busy/err got=%b required=%b",
                             e.cyc, got, e.o);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit ireq, dreq, dw, r, srv, sd, dropped_i, dropped_d;
        rst_n     = 1'b0;
        iread     = 1'b0;
        dread     = 1'b0;
        dwrite    = 1'b0;
        pmem_resp = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // icache alone: grant after one cycle, response after five cycles.
        // Then one TURN cycle and a return to IDLE.
        serve_run(1'b1, 1'b0, 1'b0, 4, 6);
        serve_run(1'b0, 1'b0, 1'b0, 4, 3);

        // Full contention, latency 4: the grants alternate I, D, I, D.
        do_reset();
        serve_run(1'b1, 1'b1, 1'b0, 4, 28);
        serve_run(1'b0, 1'b0, 1'b0, 4, 3);

        // dwrite only
        do_reset();
        serve_run(1'b0, 1'b0, 1'b1, 3, 5);
        serve_run(1'b0, 1'b0, 1'b0, 3, 3);

        // Watchdog trips with no pmem_resp; dread is re-granted afterwards.
        do_reset();
        serve_run(1'b0, 1'b1, 1'b0, 99, 16);
        serve_run(1'b0, 1'b0, 1'b0, 99, 2);

        // pmem_resp in the trip cycle is a clean completion.
        do_reset();
        serve_run(1'b0, 1'b1, 1'b0, TO, 11);
        serve_run(1'b0, 1'b0, 1'b0, TO, 3);

        // pmem_resp while IDLE sets the sticky error.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

        // icache drops its request mid-transaction: immediate error, stays in SERVE.
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

        // pmem_resp during TURN also flags an error.
        do_reset();
        serve_run(1'b1, 1'b0, 1'b0, 2, 4);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during SERVE_D
        do_reset();
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        serve_run(1'b0, 1'b0, 1'b0, 0, 1);

        // Randomized protocol-compliant traffic
        do_reset();
        ireq = 1'b0;
        dreq = 1'b0;
        dw   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r   = m_serving && (($urandom_range(0, 2) == 0) || (m_waited >= 6));
            srv = m_serving;
            sd  = m_side;
            step(ireq, dreq && !dw, dreq && dw, r);
            dropped_i = 1'b0;
            dropped_d = 1'b0;
            if (srv && r) begin
                if (sd) begin
                    dreq      = 1'b0;
                    dropped_d = 1'b1;
                end else begin
                    ireq      = 1'b0;
                    dropped_i = 1'b1;
                end
            end
            if (!ireq && !dropped_i && ($urandom_range(0, 2) == 0)) ireq = 1'b1;
            if (!dreq && !dropped_d && ($urandom_range(0, 2) == 0)) begin
                dreq = 1'b1;
                dw   = 1'($urandom_range(0, 1));
            end
        end

        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
